// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 writer.
// LCD_CURSOR_TRACK_EN adds the WRAP state used by cursor tracking.
package lcd_pkg;

    localparam int TMR_W = 20;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE0   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'hC0;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        SETUP,
        EN_HI,
        EXEC_WAIT,
        IDLE
`ifdef LCD_CURSOR_TRACK_EN
        ,
        WRAP
`endif
    } lcd_state_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNCSET;
            2'd1:    return LCD_CMD_DISPON;
            2'd2:    return LCD_CMD_CLEAR;
            default: return LCD_CMD_ENTRY;
        endcase
    endfunction

    // Clear/home family needs the long execution time.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_hd44780_writer_if.sv
// Request handshake between control logic and the LCD writer.
// Transfer happens on req_valid & req_ready.
interface lcd_hd44780_writer_if;

    logic       req_valid;
    logic [7:0] req_data;
    logic       req_rs;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_rs,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_rs,
        output req_ready
    );

endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded span.
// Comes out of reset already running from POR_VAL.
module lcd_delay_timer
    import lcd_pkg::*;
#(
    parameter logic [TMR_W-1:0] POR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             done
);

    logic [TMR_W-1:0] cnt;
    logic             busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= POR_VAL;
            busy <= 1'b1;
        end else if (load) begin
            cnt  <= value;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end

    assign done = busy && (cnt == '0);

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit write-only driver: power-up init, then byte+RS requests.
// Define LCD_CURSOR_TRACK_EN to track {line,col} and auto-wrap lines.
module lcd_hd44780_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_CYC      = 25,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 82000,
    parameter int unsigned POWERUP_CYC = 750000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    lcd_hd44780_writer_if.slave  req,
    output logic                 init_done,
    output logic [4:0]           cursor_pos,
    output logic [7:0]           LCD_DATA,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_EN,
    output logic                 LCD_ON,
    output logic                 LCD_BLON
);

    // Timer spans are loaded as N-1 so each phase lasts exactly N cycles.
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] EN_LD    = TMR_W'(EN_CYC - 1);
    localparam logic [TMR_W-1:0] EXEC_LD  = TMR_W'(EXEC_CYC - 1);
    localparam logic [TMR_W-1:0] CLEAR_LD = TMR_W'(CLEAR_CYC - 1);
    localparam logic [TMR_W-1:0] PWR_LD   = TMR_W'(POWERUP_CYC - 1);

    lcd_state_e       state;
    logic [1:0]       idx;
    logic             ready_q;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_done;

`ifdef LCD_CURSOR_TRACK_EN
    logic       line;
    logic [3:0] col;
    logic       wrap_pend;
`endif

    lcd_delay_timer #(
        .POR_VAL (PWR_LD)
    ) u_timer (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            INIT: begin
                tmr_load  = 1'b1;
                tmr_value = SETUP_LD;
            end
            IDLE: begin
                tmr_load  = req.req_valid;
                tmr_value = SETUP_LD;
            end
            SETUP: begin
                tmr_load  = tmr_done;
                tmr_value = EN_LD;
            end
            EN_HI: begin
                tmr_load  = tmr_done;
                tmr_value = is_slow_cmd(LCD_RS, LCD_DATA) ? CLEAR_LD : EXEC_LD;
            end
`ifdef LCD_CURSOR_TRACK_EN
            WRAP: begin
                tmr_load  = 1'b1;
                tmr_value = SETUP_LD;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= PWR_WAIT;
            idx       <= 2'd0;
            ready_q   <= 1'b0;
            init_done <= 1'b0;
            LCD_DATA  <= 8'h00;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
`ifdef LCD_CURSOR_TRACK_EN
            line      <= 1'b0;
            col       <= 4'd0;
            wrap_pend <= 1'b0;
`endif
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (tmr_done) begin
                        idx   <= 2'd0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    LCD_DATA <= init_cmd(idx);
                    LCD_RS   <= 1'b0;
                    state    <= SETUP;
                end
                IDLE: begin
                    if (req.req_valid) begin
                        ready_q  <= 1'b0;
                        LCD_DATA <= req.req_data;
                        LCD_RS   <= req.req_rs;
                        state    <= SETUP;
`ifdef LCD_CURSOR_TRACK_EN
                        if (req.req_rs) begin
                            col       <= col + 4'd1;
                            wrap_pend <= (col == 4'hF);
                        end else if (req.req_data == 8'h01 ||
                                     req.req_data == 8'h02) begin
                            line <= 1'b0;
                            col  <= 4'd0;
                        end else if (req.req_data[7] &&
                                     req.req_data[5:4] == 2'b00) begin
                            line <= req.req_data[6];
                            col  <= req.req_data[3:0];
                        end
`endif
                    end
                end
                SETUP: begin
                    if (tmr_done) begin
                        LCD_EN <= 1'b1;
                        state  <= EN_HI;
                    end
                end
                EN_HI: begin
                    if (tmr_done) begin
                        LCD_EN <= 1'b0;
                        state  <= EXEC_WAIT;
                    end
                end
                EXEC_WAIT: begin
                    if (tmr_done) begin
                        if (!init_done) begin
                            if (idx == 2'd3) begin
                                init_done <= 1'b1;
                                ready_q   <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                idx   <= idx + 2'd1;
                                state <= INIT;
                            end
`ifdef LCD_CURSOR_TRACK_EN
                        end else if (wrap_pend) begin
                            state <= WRAP;
`endif
                        end else begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
`ifdef LCD_CURSOR_TRACK_EN
                WRAP: begin
                    LCD_DATA  <= line ? LCD_CMD_LINE0 : LCD_CMD_LINE1;
                    LCD_RS    <= 1'b0;
                    line      <= ~line;
                    wrap_pend <= 1'b0;
                    state     <= SETUP;
                end
`endif
                default: state <= PWR_WAIT;
            endcase
        end
    end

    assign req.req_ready = ready_q;
    assign LCD_RW        = 1'b0;
    assign LCD_ON        = 1'b1;
    assign LCD_BLON      = 1'b1;

`ifdef LCD_CURSOR_TRACK_EN
    assign cursor_pos = {line, col};
`else
    assign cursor_pos = 5'd0;
`endif

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Directed bench for lcd_hd44780_writer with shortened timing.
// Build with LCD_CURSOR_TRACK_EN to also cover line wrap.
module tb_lcd_hd44780_writer;

    localparam int SETUP = 2;
    localparam int EN    = 3;
    localparam int EXEC  = 10;
    localparam int CLEAR = 40;
    localparam int PWR   = 50;
    localparam int LIM   = 5000;
    localparam int PER   = SETUP + EN + EXEC + 1;

`ifdef LCD_CURSOR_TRACK_EN
    localparam int         WRAP_EXTRA = 1;
    localparam int         WRAP_GAP   = 16;
    localparam logic [8:0] LAST_A     = {1'b0, 8'hC0};
    localparam logic [8:0] LAST_B     = {1'b0, 8'h80};
    localparam logic [4:0] CUR_A      = 5'h10;
    localparam logic [4:0] CUR_C5     = 5'h15;
`else
    localparam int         WRAP_EXTRA = 0;
    localparam int         WRAP_GAP   = 0;
    localparam logic [8:0] LAST_A     = {1'b1, 8'h61};
    localparam logic [8:0] LAST_B     = {1'b1, 8'h61};
    localparam logic [4:0] CUR_A      = 5'h00;
    localparam logic [4:0] CUR_C5     = 5'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic [4:0] cursor_pos;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

    int         vecs = 0;
    int         errs = 0;
    int         cyc = 0;
    int         hold_err = 0;
    logic       mon_on = 1'b0;
    logic [8:0] mon_val = '0;
    logic [8:0] strb_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_hd44780_writer_if bus();

    lcd_hd44780_writer #(
        .SETUP_CYC   (SETUP),
        .EN_CYC      (EN),
        .EXEC_CYC    (EXEC),
        .CLEAR_CYC   (CLEAR),
        .POWERUP_CYC (PWR)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .req        (bus),
        .init_done  (init_done),
        .cursor_pos (cursor_pos),
        .LCD_DATA   (lcd_data),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw),
        .LCD_EN     (lcd_en),
        .LCD_ON     (lcd_on),
        .LCD_BLON   (lcd_blon)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge lcd_en) strb_q.push_back({lcd_rs, lcd_data});

    always @(negedge clk)
        if (mon_on && {lcd_rs, lcd_data} !== mon_val) hold_err++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_en(input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (lcd_en !== lvl && n < LIM);
        if (lcd_en !== lvl) check("en_timeout", 32'(lcd_en), 32'(lvl));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.req_ready !== 1'b1 && n < LIM);
        if (bus.req_ready !== 1'b1) check("rdy_timeout", 32'(bus.req_ready), 1);
    endtask

    task automatic send(input logic [7:0] d, input logic r, input logic hold,
                        output int hs);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_rs    = r;
        while (bus.req_ready !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) check("send_timeout", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        hs = cyc;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hs1, hs2, hs, prev;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.req_rs    = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en",    32'(lcd_en), 0);
        check("rst_data",  32'(lcd_data), 0);
        check("rst_rs",    32'(lcd_rs), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_init",  32'(init_done), 0);
        check("rst_cur",   32'(cursor_pos), 0);
        check("tie_pins",  32'({lcd_rw, lcd_on, lcd_blon}), 32'b011);

        // Power-up wait, then the four init strobes.
        @(negedge clk) rst_n = 1'b1;
        wait_en(1'b1, n);
        check("pwr_wait", n, PWR + 1 + SETUP);
        check("init_busy", 32'(init_done), 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("init%0d_byte", k), 32'({lcd_rs, lcd_data}),
                  32'({1'b0, init_tab[k]}));
            wait_en(1'b0, n);
            check($sformatf("init%0d_en", k), n, EN);
            if (k < 3) begin
                wait_en(1'b1, n);
                check($sformatf("init%0d_gap", k), n,
                      ((k == 2) ? CLEAR : EXEC) + 1 + SETUP);
            end
        end
        wait_ready(n);
        check("init_last_wait", n, EXEC);
        check("init_done", 32'(init_done), 1);

        // Data write with hold monitoring.
        send(8'h61, 1'b1, 1'b0, hs1);
        mon_val = {1'b1, 8'h61};
        mon_on  = 1'b1;
        wait_en(1'b1, n);
        check("wr61_setup", n, SETUP);
        check("wr61_byte", 32'({lcd_rs, lcd_data}), 32'h161);
        wait_en(1'b0, n);
        check("wr61_en", n, EN);
        wait_ready(n);
        check("wr61_exec", n, EXEC);
        mon_on = 1'b0;
        check("wr61_hold", hold_err, 0);

        send(8'h01, 1'b0, 1'b0, hs2);
        check("latency", hs2 - hs1, PER);
        wait_en(1'b1, n);
        wait_en(1'b0, n);
        wait_ready(n);
        check("clr_wait", n, CLEAR);

        send(8'h01, 1'b1, 1'b0, hs1);
        wait_en(1'b1, n);
        wait_en(1'b0, n);
        wait_ready(n);
        check("data01_wait", n, EXEC);

        // Cursor tracking and wrap.
        send(8'h01, 1'b0, 1'b0, hs);
        wait_ready(n);
        check("cur_clear", 32'(cursor_pos), 0);
        strb_q.delete();
        for (int i = 0; i < 16; i++) send(8'h61, 1'b1, 1'b0, hs);
        wait_ready(n);
        check("wrap1_cnt", strb_q.size(), 16 + WRAP_EXTRA);
        check("wrap1_last", 32'(strb_q[strb_q.size()-1]), 32'(LAST_A));
        check("wrap1_cur", 32'(cursor_pos), 32'(CUR_A));
        strb_q.delete();
        for (int i = 0; i < 16; i++) send(8'h61, 1'b1, 1'b0, hs);
        wait_ready(n);
        check("wrap2_cnt", strb_q.size(), 16 + WRAP_EXTRA);
        check("wrap2_last", 32'(strb_q[strb_q.size()-1]), 32'(LAST_B));
        check("wrap2_cur", 32'(cursor_pos), 0);
        send(8'hC5, 1'b0, 1'b0, hs);
        wait_ready(n);
        check("cur_setaddr", 32'(cursor_pos), 32'(CUR_C5));
        send(8'h02, 1'b0, 1'b0, hs);
        wait_ready(n);
        check("cur_home", 32'(cursor_pos), 0);

        // Back-to-back letters with req_valid held.
        strb_q.delete();
        exp_q.delete();
        prev = 0;
        for (int i = 0; i < 26; i++) begin
            exp_q.push_back({1'b1, 8'(8'h61 + i)});
`ifdef LCD_CURSOR_TRACK_EN
            if (i == 15) exp_q.push_back({1'b0, 8'hC0});
`endif
            send(8'(8'h61 + i), 1'b1, 1'b1, hs);
            if (i > 0)
                check($sformatf("b2b_gap%0d", i), hs - prev,
                      PER + ((i == 16) ? WRAP_GAP : 0));
            prev = hs;
        end
        bus.req_valid = 1'b0;
        wait_ready(n);
        check("b2b_cnt", strb_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < strb_q.size(); j++)
            check($sformatf("b2b_byte%0d", j), 32'(strb_q[j]), 32'(exp_q[j]));

        // Reset in the middle of an EN pulse.
        send(8'h61, 1'b1, 1'b0, hs);
        wait_en(1'b1, n);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en", 32'(lcd_en), 0);
        check("midrst_init", 32'(init_done), 0);
        check("midrst_ready", 32'(bus.req_ready), 0);
        check("midrst_cur", 32'(cursor_pos), 0);
        @(negedge clk) rst_n = 1'b1;
        wait_en(1'b1, n);
        check("restart_wait", n, PWR + 1 + SETUP);
        check("restart_byte", 32'({lcd_rs, lcd_data}), 32'h038);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
